// File: rtl/lc3b_types.sv
// Shared LC-3b types: address word, cache-line vector and the memory arbiter
// state/grant encodings.
package lc3b_types;

   typedef logic [15:0] lc3b_word;

   localparam int unsigned LC3B_LINE_WIDTH = 128;
   typedef logic [LC3B_LINE_WIDTH-1:0] lc3b_line;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } arb_state_e;

   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } arb_grant_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data cache) arbiter in front of a single physical
// memory; round-robin on ties, one transaction in flight at a time.
module mem_arbiter
   import lc3b_types::*;
#(
   parameter int unsigned LINE_WIDTH = LC3B_LINE_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,

   input  logic                  i_read,
   input  lc3b_word              i_address,
   output logic [LINE_WIDTH-1:0] i_rdata,
   output logic                  i_resp,

   input  logic                  d_read,
   input  logic                  d_write,
   input  lc3b_word              d_address,
   input  logic [LINE_WIDTH-1:0] d_wdata,
   output logic [LINE_WIDTH-1:0] d_rdata,
   output logic                  d_resp,

   output logic                  pmem_read,
   output logic                  pmem_write,
   output lc3b_word              pmem_address,
   output logic [LINE_WIDTH-1:0] pmem_wdata,
   input  logic [LINE_WIDTH-1:0] pmem_rdata,
   input  logic                  pmem_resp
);

   arb_state_e            state, next_state;
   arb_grant_e            last_grant, next_grant;
   logic                  grant_i, grant_d;
   logic                  i_req, d_req;
   lc3b_word              addr_q;
   logic                  write_q;
   logic [LINE_WIDTH-1:0] wdata_q;

   assign i_req = i_read;
   assign d_req = d_read | d_write;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= GRANT_I;
      end else begin
         state      <= next_state;
         last_grant <= next_grant;
      end
   end

   // Grants are only issued from IDLE, which forces an idle cycle between
   // transactions so a requester that drops after its resp is never re-served.
   always_comb begin
      next_state = state;
      next_grant = last_grant;
      grant_i    = 1'b0;
      grant_d    = 1'b0;
      case (state)
         IDLE: begin
            if (i_req && d_req) begin
               if (last_grant == GRANT_I) grant_d = 1'b1;
               else                       grant_i = 1'b1;
            end else if (i_req) begin
               grant_i = 1'b1;
            end else if (d_req) begin
               grant_d = 1'b1;
            end
            if (grant_i) begin
               next_state = SERVE_I;
               next_grant = GRANT_I;
            end else if (grant_d) begin
               next_state = SERVE_D;
               next_grant = GRANT_D;
            end
         end
         SERVE_I, SERVE_D: begin
            if (pmem_resp) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // The transaction is frozen at grant time; requester changes while it is
   // in flight have no effect. A simultaneous read+write is a write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
      end else if (grant_i) begin
         addr_q  <= i_address;
         write_q <= 1'b0;
      end else if (grant_d) begin
         addr_q  <= d_address;
         write_q <= d_write;
         if (d_write) wdata_q <= d_wdata;
      end
   end

   assign pmem_read    = (state != IDLE) && !write_q;
   assign pmem_write   = (state != IDLE) &&  write_q;
   assign pmem_address = addr_q;
   assign pmem_wdata   = wdata_q;

   assign i_resp  = (state == SERVE_I) && pmem_resp;
   assign d_resp  = (state == SERVE_D) && pmem_resp;
   assign i_rdata = i_resp ? pmem_rdata : '0;
   assign d_rdata = d_resp ? pmem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter: expected transactions are queued
// when requests are driven and checked as physical memory serves them.
module tb_mem_arbiter;

   localparam int LW = 128;
   localparam logic [LW-1:0] GARBAGE = {4{32'hDEADBEEF}};

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_read;
   logic [15:0]   i_address;
   logic [LW-1:0] i_rdata;
   logic          i_resp;
   logic          d_read, d_write;
   logic [15:0]   d_address;
   logic [LW-1:0] d_wdata, d_rdata;
   logic          d_resp;
   logic          pmem_read, pmem_write;
   logic [15:0]   pmem_address;
   logic [LW-1:0] pmem_wdata, pmem_rdata;
   logic          pmem_resp;

   typedef struct {
      logic          is_d;
      logic          write;
      logic [15:0]   addr;
      logic [LW-1:0] wdata;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   mem_arbiter #(.LINE_WIDTH(LW)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_address(d_address),
      .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
      .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic is_d, input logic write, input logic [15:0] addr,
                           input logic [LW-1:0] wdata);
      exp_t e;
      e.is_d = is_d; e.write = write; e.addr = addr; e.wdata = wdata;
      sb.push_back(e);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_i_resp"}, i_resp, 1'b0);
      check({tag, "_d_resp"}, d_resp, 1'b0);
      check({tag, "_i_rdata"}, i_rdata, '0);
      check({tag, "_d_rdata"}, d_rdata, '0);
   endtask

   // Wait for the next pmem command, compare it with the oldest expected
   // transaction, hold for 'hold' cycles, then respond with 'rdata'.
   task automatic serve(input int exp_lat, input int hold, input logic [LW-1:0] rdata,
                        input bit mutate);
      exp_t e;
      int   lat;
      bit   seen;
      seen = 1'b0;
      lat  = 0;
      for (int n = 1; n <= 20; n++) begin
         tick();
         if (pmem_read || pmem_write) begin
            seen = 1'b1;
            lat  = n;
            break;
         end
      end
      check("grant_latency", LW'(lat), LW'(exp_lat));
      if (!seen || sb.size() == 0) begin
         check("scoreboard_underflow", LW'(sb.size()), LW'(1));
         return;
      end
      e = sb.pop_front();
      check("cmd_addr", pmem_address, e.addr);
      check("cmd_read", pmem_read, !e.write);
      check("cmd_write", pmem_write, e.write);
      if (e.write) check("cmd_wdata", pmem_wdata, e.wdata);
      check_quiet("cmd_first");
      for (int k = 0; k < hold; k++) begin
         if (mutate && k == 0) begin
            d_address = 16'h5000;
            d_read    = 1'b0;
         end
         tick();
         check("hold_addr", pmem_address, e.addr);
         check("hold_read", pmem_read, !e.write);
         check("hold_write", pmem_write, e.write);
         check_quiet("hold");
      end
      pmem_rdata = rdata;
      pmem_resp  = 1'b1;
      #1;
      check("resp_i", i_resp, !e.is_d);
      check("resp_d", d_resp, e.is_d);
      check("resp_i_rdata", i_rdata, e.is_d ? '0 : rdata);
      check("resp_d_rdata", d_rdata, e.is_d ? rdata : '0);
      @(posedge clk);
      #1;
      pmem_resp  = 1'b0;
      pmem_rdata = GARBAGE;
      check("gap_cmd", {pmem_read, pmem_write}, 2'b00);
      check_quiet("gap");
   endtask

   initial begin
      rst_n = 1'b0;
      i_read = 1'b0; i_address = '0;
      d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
      pmem_rdata = GARBAGE; pmem_resp = 1'b0;

      #12;
      check("rst_cmd", {pmem_read, pmem_write}, 2'b00);
      check("rst_addr", pmem_address, 16'h0000);
      check("rst_wdata", pmem_wdata, '0);
      check_quiet("rst");
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      $display("[TB] lone instruction fill");
      i_read = 1'b1; i_address = 16'h1230;
      push_exp(1'b0, 1'b0, 16'h1230, '0);
      serve(1, 3, {16{8'hA5}}, 1'b0);
      i_read = 1'b0;

      $display("[TB] data writeback");
      d_write = 1'b1; d_address = 16'h4000;
      d_wdata = 128'h0123456789ABCDEF0123456789ABCDEF;
      push_exp(1'b1, 1'b1, 16'h4000, 128'h0123456789ABCDEF0123456789ABCDEF);
      d_wdata = 128'h0123456789ABCDEF0123456789ABCDEF;
      serve(1, 2, 128'h11112222333344445555666677778888, 1'b0);
      d_write = 1'b0;

      $display("[TB] read+write together is a write");
      d_read = 1'b1; d_write = 1'b1; d_address = 16'h4440; d_wdata = {8{16'hC0DE}};
      push_exp(1'b1, 1'b1, 16'h4440, {8{16'hC0DE}});
      serve(1, 1, {8{16'h0F0F}}, 1'b0);
      d_read = 1'b0; d_write = 1'b0;

      $display("[TB] mid-transaction request change");
      d_read = 1'b1; d_address = 16'h4000;
      push_exp(1'b1, 1'b0, 16'h4000, '0);
      serve(1, 3, {4{32'h600DF00D}}, 1'b1);
      tick();
      check("drop_no_regrant", {pmem_read, pmem_write}, 2'b00);

      $display("[TB] reset abort");
      i_read = 1'b1; i_address = 16'h2222;
      tick();
      tick();
      check("abort_pre_read", pmem_read, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_async_read", pmem_read, 1'b0);
      check("abort_async_addr", pmem_address, 16'h0000);
      pmem_resp = 1'b1;
      #1;
      check("abort_no_i_resp", i_resp, 1'b0);
      check("abort_no_i_rdata", i_rdata, '0);
      pmem_resp = 1'b0;
      i_read = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("abort_idle", {pmem_read, pmem_write}, 2'b00);

      $display("[TB] ties after reset alternate starting with data");
      i_read = 1'b1; i_address = 16'h3000;
      d_read = 1'b1; d_address = 16'h6000;
      push_exp(1'b1, 1'b0, 16'h6000, '0);
      push_exp(1'b0, 1'b0, 16'h3000, '0);
      push_exp(1'b1, 1'b0, 16'h6000, '0);
      serve(1, 1, {4{32'hAAAA0001}}, 1'b0);
      serve(1, 0, {4{32'hBBBB0002}}, 1'b0);
      serve(1, 2, {4{32'hCCCC0003}}, 1'b0);
      i_read = 1'b0; d_read = 1'b0;

      $display("[TB] stray memory response");
      tick();
      pmem_rdata = {4{32'h57A7}};
      pmem_resp  = 1'b1;
      #1;
      check_quiet("stray");
      @(posedge clk);
      #1;
      pmem_resp  = 1'b0;
      pmem_rdata = GARBAGE;
      tick();
      check("stray_idle", {pmem_read, pmem_write}, 2'b00);
      d_read = 1'b1; d_address = 16'h7000;
      push_exp(1'b1, 1'b0, 16'h7000, '0);
      serve(1, 0, {4{32'h12345678}}, 1'b0);
      d_read = 1'b0;

      check("scoreboard_empty", LW'(sb.size()), LW'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LINE_WIDTH, default 128, width in bits of one cache line moved per transaction.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_read  input  1  instruction-cache line-fill request.
REQ-005 i_address  input  16 (lc3b_word)  instruction line address.
REQ-006 i_rdata  output  LINE_WIDTH  fill data to the instruction cache.
REQ-007 i_resp  output  1  instruction transaction complete.
REQ-008 d_read  input  1  data-cache line-fill request.
REQ-009 d_write  input  1  data-cache writeback request.
REQ-010 d_address  input  16  data line address.
REQ-011 d_wdata  input  LINE_WIDTH  writeback line.
REQ-012 d_rdata  output  LINE_WIDTH  fill data to the data cache.
REQ-013 d_resp  output  1  data transaction complete.
REQ-014 pmem_read, pmem_write  output  1 each  physical-memory commands.
REQ-015 pmem_address  output  16  physical-memory line address.
REQ-016 pmem_wdata  output  LINE_WIDTH  physical-memory write line.
REQ-017 pmem_rdata  input  LINE_WIDTH  physical-memory read line.
REQ-018 pmem_resp  input  1  physical-memory completion, one-cycle pulse.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, SERVE_I and SERVE_D.
REQ-020 In IDLE with a single pending request (i_read, or d_read|d_write), the arbiter SHALL enter that requester's SERVE state on the next edge.
REQ-021 In IDLE with both requesters pending, the arbiter SHALL grant the requester not granted last (last_grant flag); after reset last_grant = I, so D wins the first tie.
REQ-022 On a grant, the arbiter SHALL latch address, op (read/write) and, for D writes, d_wdata into internal registers; pmem_* outputs SHALL be driven only from these registers.
REQ-023 In SERVE_x, exactly one of pmem_read/pmem_write SHALL be asserted, held until pmem_resp.
REQ-024 d_read and d_write both high SHALL be treated as a write.
REQ-025 On pmem_resp in SERVE_x, x_resp SHALL pulse high for that same cycle (combinational pass-through); x_rdata SHALL equal pmem_rdata that cycle; the FSM SHALL return to IDLE.
REQ-026 i_rdata and d_rdata SHALL be 0 except when that requester's resp is high; the non-granted resp SHALL never pulse.
REQ-027 The FSM SHALL spend at least one cycle in IDLE between transactions, so a requester dropping its request after resp is never re-granted.
REQ-028 Request changes or drops during SERVE_x SHALL not alter the latched transaction; it completes at pmem_resp.
REQ-029 pmem_resp arriving in IDLE SHALL be ignored.
REQ-030 Minimum grant latency SHALL be one cycle (request seen in IDLE -> pmem command next cycle).
REQ-031 Bounded fairness: with both requesters continuously pending, grants SHALL strictly alternate.

Reset
REQ-032 While rst_n is low: state = IDLE, last_grant = I, latched registers = 0, all outputs 0.
REQ-033 Reset asserted mid-transaction SHALL abort it immediately with no resp pulse; pmem commands drop asynchronously.

Structure
REQ-034 The arbiter state enum and the cache-line type (LINE_WIDTH-bit vector) SHALL live in lc3b_types.
REQ-035 The block SHALL be a single module with no sub-modules; FSM next-state logic, latch registers and output muxing live inline.

Verification
REQ-036 Lone I fill: i_read, i_address=0x1230, pmem_resp after 3 cycles with rdata=0xA5..A5 -> pmem_read with address 0x1230 one cycle after request; i_resp pulses once with i_rdata=0xA5..A5; d_resp stays 0.
REQ-037 D writeback: d_write, d_address=0x4000, d_wdata=0x0123..EF -> pmem_write with latched data; d_resp pulses on pmem_resp; pmem_read never asserted.
REQ-038 Tie after reset: i_read and d_read asserted together and held -> D served first, then I after one IDLE cycle; a further tie grants D.
REQ-039 Mid-transaction change: during SERVE_D, change d_address from 0x4000 to 0x5000 and drop d_read -> pmem_address stays 0x4000 until pmem_resp.
REQ-040 Reset abort: assert rst_n=0 during SERVE_I before pmem_resp -> pmem_read falls without waiting for a clock edge; no i_resp; after release, state is IDLE and the next tie grants D.
REQ-041 Stray response: pmem_resp pulsed in IDLE with no requests -> no resp output and no state change.
